// File: rtl/soc_video_scanout.sv
// VGA scan-out engine: timing generator, framebuffer address sequencer and registered pixel decode.
// Optional palette lookup for pixel mode 2 is built when SOC_VIDEO_PALETTE_EN is defined.
module soc_video_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int FB_LATENCY  = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  enable,
  input  logic [1:0]            pxl_mode,
  output logic [ADDR_WIDTH-1:0] pxl_addr,
  input  logic [7:0]            pxl_data,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vblank_irq,
  output logic [15:0]           frame_cnt
`ifdef SOC_VIDEO_PALETTE_EN
  ,
  input  logic                  pal_we,
  input  logic [7:0]            pal_idx,
  input  logic [11:0]           pal_wdata
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK   = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_W = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);

  typedef enum logic [1:0] {
    MODE_RGB332   = 2'd0,
    MODE_GREY8    = 2'd1,
    MODE_PALETTE  = 2'd2,
    MODE_RESERVED = 2'd3
  } pxl_mode_e;

  logic [HW-1:0]         h_cnt, h_next;
  logic [VW-1:0]         v_cnt, v_next;
  logic                  h_last, v_last, frame_wrap, line_step;
  logic                  active, hs_on, vs_on;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [FB_LATENCY:0]   act_pipe, hs_pipe, vs_pipe;
  logic [11:0]           pix_rgb;
  pxl_mode_e             mode;

`ifdef SOC_VIDEO_PALETTE_EN
  logic [11:0] palette [256];

  // Palette has no reset; contents persist across res.
  always_ff @(posedge clk) begin
    if (pal_we) palette[pal_idx] <= pal_wdata;
  end
`endif

  always_comb begin
    h_last     = (h_cnt == H_LAST);
    v_last     = (v_cnt == V_LAST);
    h_next     = h_last ? '0 : h_cnt + HW'(1);
    v_next     = v_cnt;
    if (h_last) v_next = v_last ? '0 : v_cnt + VW'(1);
    frame_wrap = h_last && v_last;
    // A new framebuffer row starts only every 2^SCALE_SHIFT display lines.
    line_step  = h_last && !v_last && ((v_next & V_MASK) == '0);
    active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_on      = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_on      = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  always_comb begin
    mode    = pxl_mode_e'(pxl_mode);
    pix_rgb = '0;
    case (mode)
      MODE_RGB332: pix_rgb = {pxl_data[7:5], pxl_data[7], pxl_data[4:2], pxl_data[4],
                              pxl_data[1:0], pxl_data[1:0]};
      MODE_GREY8:  pix_rgb = {pxl_data[7:4], pxl_data[7:4], pxl_data[7:4]};
`ifdef SOC_VIDEO_PALETTE_EN
      // Read before the same-edge write lands, so a colliding write shows the old entry.
      MODE_PALETTE: pix_rgb = palette[pxl_data];
`endif
      default:     pix_rgb = '0;
    endcase
    if (!act_pipe[FB_LATENCY] || !enable) pix_rgb = '0;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      line_base  <= '0;
      pxl_addr   <= '0;
      frame_cnt  <= '0;
      vblank_irq <= 1'b0;
      act_pipe   <= '0;
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      vga_hsync  <= ~HS_POL;
      vga_vsync  <= ~VS_POL;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
      if (frame_wrap)     line_base <= '0;
      else if (line_step) line_base <= line_base + LINE_W;
      if (active) pxl_addr <= line_base + ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
      if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
      vblank_irq <= h_last && (v_next == V_ACT);
      // Stage k holds the flags for the address issued k+1 cycles ago; the last stage meets pxl_data.
      act_pipe <= {act_pipe[FB_LATENCY-1:0], active};
      hs_pipe  <= {hs_pipe[FB_LATENCY-1:0], hs_on};
      vs_pipe  <= {vs_pipe[FB_LATENCY-1:0], vs_on};
      vga_hsync <= hs_pipe[FB_LATENCY] ? HS_POL : ~HS_POL;
      vga_vsync <= vs_pipe[FB_LATENCY] ? VS_POL : ~VS_POL;
      {vga_r, vga_g, vga_b} <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_soc_video_scanout.sv
// Directed bench for soc_video_scanout: small 14x7 raster, FB latency 2, scaled and unscaled instances.
module tb_soc_video_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res, enable;
  logic [1:0]  pxl_mode;
  logic [7:0]  fb_xor;
  logic [31:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic        hs0, vs0, irq0, hs1, vs1, irq1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic [15:0] fc0, fc1;
  logic [7:0]  fb0_a, fb0_b, fb1_a, fb1_b;
`ifdef SOC_VIDEO_PALETTE_EN
  logic        pal_we;
  logic [7:0]  pal_idx;
  logic [11:0] pal_wdata;
`endif

  int n;
  int checks = 0;
  int failures = 0;

  // Framebuffer models: data = addr[7:0] two cycles after the address, optionally XOR-ed.
  always @(posedge clk) begin
    fb0_a <= addr0[7:0];
    fb0_b <= fb0_a;
    fb1_a <= addr1[7:0];
    fb1_b <= fb1_a;
  end
  assign data0 = fb0_b ^ fb_xor;
  assign data1 = fb1_b;

  soc_video_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(0), .FB_LATENCY(2), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .res(res), .enable(enable), .pxl_mode(pxl_mode),
    .pxl_addr(addr0), .pxl_data(data0),
    .vga_hsync(hs0), .vga_vsync(vs0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .vblank_irq(irq0), .frame_cnt(fc0)
`ifdef SOC_VIDEO_PALETTE_EN
    , .pal_we(pal_we), .pal_idx(pal_idx), .pal_wdata(pal_wdata)
`endif
  );

  soc_video_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(1), .FB_LATENCY(2), .ADDR_WIDTH(32)
  ) dut_s (
    .clk(clk), .res(res), .enable(enable), .pxl_mode(pxl_mode),
    .pxl_addr(addr1), .pxl_data(data1),
    .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vblank_irq(irq1), .frame_cnt(fc1)
`ifdef SOC_VIDEO_PALETTE_EN
    , .pal_we(1'b0), .pal_idx(8'h00), .pal_wdata(12'h000)
`endif
  );

  typedef struct {
    logic [1:0]  mode;
    logic        en;
    logic [7:0]  xr;
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!res) n = 0;
    else n = n + 1;
    #1;
  endtask

  function automatic int hp(input int k);
    return k % 14;
  endfunction

  function automatic int vp(input int k);
    return (k / 14) % 7;
  endfunction

  function automatic bit in_active(input int k);
    return (hp(k) < 8) && (vp(k) < 4);
  endfunction

  task automatic goto_pos(input int tgt);
    for (int g = 0; g < 98 && (n % 98) != tgt; g++) tick();
  endtask

  task automatic check_pins(input string name, input logic [11:0] rgb, input logic hs, input logic vs);
    check({name, "_rgb"}, 32'({r0, g0, b0}), 32'(rgb));
    check({name, "_hs"}, 32'(hs0), 32'(hs));
    check({name, "_vs"}, 32'(vs0), 32'(vs));
  endtask

  // Per-cycle raster checks measured from the last reset edge (n = 0 at counters (0,0)).
  task automatic run_timing(input int cycles);
    logic exp_hs, exp_vs;
    for (int i = 0; i < cycles; i++) begin
      exp_hs = (n < 4) ? 1'b1 : !((hp(n - 4) >= 10) && (hp(n - 4) < 12));
      exp_vs = (n < 4) ? 1'b1 : (vp(n - 4) != 5);
      check("hsync", 32'(hs0), 32'(exp_hs));
      check("vsync", 32'(vs0), 32'(exp_vs));
      check("hsync_scaled", 32'(hs1), 32'(exp_hs));
      check("vsync_scaled", 32'(vs1), 32'(exp_vs));
      check("vblank_irq", 32'(irq0), 32'(n % 98 == 56));
      check("vblank_irq_scaled", 32'(irq1), 32'(n % 98 == 56));
      check("frame_cnt", 32'(fc0), 32'(n / 98));
      check("frame_cnt_scaled", 32'(fc1), 32'(n / 98));
      if (n < 4 || !in_active(n - 4)) begin
        check("blank_rgb", 32'({r0, g0, b0}), 32'h0);
        check("blank_rgb_scaled", 32'({r1, g1, b1}), 32'h0);
      end
      if (n >= 1 && in_active(n - 1)) begin
        check("addr", addr0, 32'(vp(n - 1) * 8 + hp(n - 1)));
        check("addr_scaled", addr1, 32'((vp(n - 1) >> 1) * 4 + (hp(n - 1) >> 1)));
      end
      if (n >= 1 && hp(n - 1) == 9 && vp(n - 1) < 4)
        check("addr_scaled_hold", addr1, 32'((vp(n - 1) >> 1) * 4 + 3));
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            mode  en  xor    h   v   rgb      hs    vs
    vecs[0]  = '{2'd0, 1'b1, 8'h00,  5, 0, 12'h025, 1'b1, 1'b1};
    vecs[1]  = '{2'd0, 1'b1, 8'hE0,  3, 1, 12'hF4F, 1'b1, 1'b1};
    vecs[2]  = '{2'd0, 1'b1, 8'hA4,  0, 2, 12'hBB0, 1'b1, 1'b1};
    vecs[3]  = '{2'd1, 1'b1, 8'h80,  7, 3, 12'h999, 1'b1, 1'b1};
    vecs[4]  = '{2'd1, 1'b1, 8'h00,  6, 2, 12'h111, 1'b1, 1'b1};
    vecs[5]  = '{2'd3, 1'b1, 8'h80,  2, 0, 12'h000, 1'b1, 1'b1};
    vecs[6]  = '{2'd0, 1'b0, 8'hE0,  4, 1, 12'h000, 1'b1, 1'b1};
    vecs[7]  = '{2'd0, 1'b1, 8'hE0, 10, 1, 12'h000, 1'b0, 1'b1};
    vecs[8]  = '{2'd0, 1'b1, 8'hE0,  9, 0, 12'h000, 1'b1, 1'b1};
    vecs[9]  = '{2'd0, 1'b1, 8'hE0, 12, 2, 12'h000, 1'b1, 1'b1};
    vecs[10] = '{2'd1, 1'b1, 8'hF0,  3, 5, 12'h000, 1'b1, 1'b0};
    vecs[11] = '{2'd1, 1'b1, 8'hF0, 11, 5, 12'h000, 1'b0, 1'b0};
    vecs[12] = '{2'd1, 1'b1, 8'hF0,  3, 4, 12'h000, 1'b1, 1'b1};
    vecs[13] = '{2'd1, 1'b1, 8'hF0, 13, 6, 12'h000, 1'b1, 1'b1};
    vecs[14] = '{2'd0, 1'b1, 8'h00,  7, 0, 12'h02F, 1'b1, 1'b1};
    vecs[15] = '{2'd0, 1'b1, 8'h00,  8, 0, 12'h000, 1'b1, 1'b1};

    res = 1'b0;
    enable = 1'b1;
    pxl_mode = 2'd0;
    fb_xor = 8'h00;
    n = 0;
`ifdef SOC_VIDEO_PALETTE_EN
    pal_we = 1'b0;
    pal_idx = 8'h00;
    pal_wdata = 12'h000;
`endif
    repeat (3) tick();
    res = 1'b1;

    // Two full frames plus a little: sync timing, irq, frame count, blanking, address order.
    run_timing(2 * 98 + 2);

    // Pixel decode vectors: pins sampled four cycles after the counters reach (h,v).
    for (int i = 0; i < 16; i++) begin
      pxl_mode = vecs[i].mode;
      enable   = vecs[i].en;
      fb_xor   = vecs[i].xr;
      goto_pos(vecs[i].v * 14 + vecs[i].h);
      repeat (4) tick();
      check_pins($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].hs, vecs[i].vs);
    end

    // Exact latency: address one cycle after (5,0), pixel at the pins four cycles after.
    pxl_mode = 2'd0;
    enable = 1'b1;
    fb_xor = 8'h00;
    goto_pos(5);
    tick();
    check("lat_addr", addr0, 32'd5);
    repeat (2) tick();
    check("lat_prev_pixel", 32'({r0, g0, b0}), 32'h020);
    tick();
    check("lat_pixel5", 32'({r0, g0, b0}), 32'h025);

    // enable dropped mid-line: last enabled pixel (3,1), then black; syncs keep their timing.
    goto_pos(1 * 14 + 7);
    check("en_last_pixel", 32'({r0, g0, b0}), 32'h04F);
    enable = 1'b0;
    tick();
    check("en_off_pixel4", 32'({r0, g0, b0}), 32'h000);
    tick();
    check("en_off_pixel5", 32'({r0, g0, b0}), 32'h000);
    goto_pos(1 * 14 + 13);
    check("en_off_hs_h9", 32'(hs0), 32'd1);
    tick();
    check("en_off_hs_h10", 32'(hs0), 32'd0);
    repeat (2) tick();
    check("en_off_hs_h12", 32'(hs0), 32'd1);
    enable = 1'b1;

`ifdef SOC_VIDEO_PALETTE_EN
    pal_we = 1'b1;
    pal_idx = 8'h05;
    pal_wdata = 12'hF0A;
    tick();
    pal_we = 1'b0;
    pxl_mode = 2'd2;
    goto_pos(5);
    repeat (4) tick();
    check("pal_pixel5", 32'({r0, g0, b0}), 32'hF0A);
    goto_pos(5);
    repeat (3) tick();
    pal_we = 1'b1;
    pal_idx = 8'h05;
    pal_wdata = 12'h123;
    tick();
    pal_we = 1'b0;
    check("pal_collide_old", 32'({r0, g0, b0}), 32'hF0A);
    goto_pos(5);
    repeat (4) tick();
    check("pal_new_entry", 32'({r0, g0, b0}), 32'h123);
`else
    pxl_mode = 2'd2;
    goto_pos(5);
    repeat (4) tick();
    check("mode2_black", 32'({r0, g0, b0}), 32'h000);
`endif
    pxl_mode = 2'd0;

    // One-cycle reset at counters (6,2): everything restarts from (0,0).
    goto_pos(2 * 14 + 6);
    check("pre_reset_frame_cnt", 32'(fc0), 32'(n / 98));
    res = 1'b0;
    tick();
    res = 1'b1;
    check("rst_addr", addr0, 32'd0);
    check("rst_addr_scaled", addr1, 32'd0);
    check("rst_frame_cnt", 32'(fc0), 32'd0);
    check_pins("rst", 12'h000, 1'b1, 1'b1);
    check("rst_irq", 32'(irq0), 32'd0);
    run_timing(98 + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
